// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder
// ----------------------------------------------------------------------------
// Bit-serial WIDTH-bit adder. Two operands are captured on an accepted
// `start` and fed LSB-first through a single full-adder cell. A carry
// flip-flop carries the ripple from one bit to the next. Result bits are
// assembled MSB-inserted in a shift register, so after WIDTH cycles the
// register holds the sum in natural bit order. Completion is flagged with
// a one-cycle `done` pulse.
//
// Parameters:
//   WIDTH  operand/result width in bits (1..32), default 8
//
// Ports:
//   clk    in   1      system clock, rising edge
//   rst    in   1      synchronous reset, active-high, highest priority
//   start  in   1      request a new operation (accepted in IDLE or DONE)
//   sub    in   1      (only with SERIAL_ADDER_SUB_EN) 1 = compute a-b
//   a      in   WIDTH  operand A, sampled on accepted start
//   b      in   WIDTH  operand B, sampled on accepted start
//   busy   out  1      high while bits are being processed (SHIFT)
//   done   out  1      one-cycle pulse, sum/cout valid from this cycle on
//   sum    out  WIDTH  registered result, held until the next completion
//   cout   out  1      registered final carry (subtract: 1 = no borrow)
//
// Build option:
//   SERIAL_ADDER_SUB_EN  adds the `sub` port. Subtraction loads ~b into the
//                        B shift register and seeds the carry with 1, which
//                        is a + ~b + 1 = a - b in two's complement.
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter is at least one bit wide so WIDTH=1 still has a legal vector.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Full-adder cell helpers: sum is the 3-input parity, carry is the
    // generate term OR the propagated incoming carry.
    // ------------------------------------------------------------------
    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        fa_sum = x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        fa_carry = (x & y) | (c & (x ^ y));
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] res_shift_s;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_r;
    logic             bit_s;
    logic             carry_nxt_s;
    logic             accept_s;
    logic             last_s;
    logic [WIDTH-1:0] b_load_s;
    logic             carry_init_s;
    logic             busy_r;
    logic             done_r;
    logic             busy_nxt_s;
    logic             done_nxt_s;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    // Per-bit arithmetic on the current LSBs of the operand shift registers.
    always_comb begin
        bit_s       = fa_sum(a_sr_r[0], b_sr_r[0], carry_r);
        carry_nxt_s = fa_carry(a_sr_r[0], b_sr_r[0], carry_r);
    end

    // New result bit enters at the MSB; WIDTH=1 has no older bits to keep.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_shift_s = bit_s;
        end else begin : g_res_wn
            assign res_shift_s = {bit_s, res_r[WIDTH-1:1]};
        end
    endgenerate

    // Operand-load values: plain add, or a + ~b + 1 when subtracting.
    always_comb begin
        b_load_s     = b;
        carry_init_s = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_load_s     = ~b;
            carry_init_s = 1'b1;
        end else begin
            b_load_s     = b;
            carry_init_s = 1'b0;
        end
`endif
    end

    // Request acceptance and last-bit detection decoded from current state.
    always_comb begin
        accept_s = 1'b0;
        last_s   = 1'b0;
        case (state_r)
            IDLE:    accept_s = start;
            DONE:    accept_s = start;
            SHIFT:   last_s   = (cnt_r == LAST_CNT);
            default: begin
                accept_s = 1'b0;
                last_s   = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; a request in DONE is taken exactly as in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DONE: begin
                if (accept_s) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output decode from the next state so busy/done can be registered
    // and still line up with the state they describe.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            IDLE:    begin busy_nxt_s = 1'b0; done_nxt_s = 1'b0; end
            SHIFT:   begin busy_nxt_s = 1'b1; done_nxt_s = 1'b0; end
            DONE:    begin busy_nxt_s = 1'b0; done_nxt_s = 1'b1; end
            default: begin busy_nxt_s = 1'b0; done_nxt_s = 1'b0; end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    // Datapath: operand capture, bit-serial shifting, result commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr_r  <= '0;
            b_sr_r  <= '0;
            res_r   <= '0;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        a_sr_r  <= a;
                        b_sr_r  <= b_load_s;
                        res_r   <= '0;
                        cnt_r   <= '0;
                        carry_r <= carry_init_s;
                    end else begin
                        a_sr_r  <= a_sr_r;
                        b_sr_r  <= b_sr_r;
                    end
                end
                SHIFT: begin
                    a_sr_r  <= a_sr_r >> 1'b1;
                    b_sr_r  <= b_sr_r >> 1'b1;
                    res_r   <= res_shift_s;
                    carry_r <= carry_nxt_s;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    // sum/cout only move on the edge that enters DONE.
                    if (last_s) begin
                        sum_r  <= res_shift_s;
                        cout_r <= carry_nxt_s;
                    end else begin
                        sum_r  <= sum_r;
                        cout_r <= cout_r;
                    end
                end
                default: begin
                    a_sr_r  <= '0;
                    b_sr_r  <= '0;
                    carry_r <= 1'b0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// ============================================================================
// tb_serial_adder
// ----------------------------------------------------------------------------
// Directed plus randomized checks of serial_adder (WIDTH=8). Expected results
// come from plain integer arithmetic: {cout,sum} = a + b, or for subtraction
// sum = a - b mod 2^8 and cout = (a >= b).
// ============================================================================
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif

    int n_vec     = 0;
    int n_miscmp  = 0;

    // Last completed result according to the model; sum/cout must hold it.
    logic [W-1:0] held_sum;
    logic         held_cout;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miscmp++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Issue one operation and follow it to its done pulse. If glitch_k >= 0,
    // a stray start with other operands is driven k cycles into SHIFT.
    // Returns sampling the DONE cycle, so a following call is back-to-back.
    task automatic do_op(input string tag, input logic [W-1:0] ta,
                         input logic [W-1:0] tb_v, input logic tsub,
                         input int glitch_k);
        logic [W:0]   tot;
        logic [W-1:0] es;
        logic         ec;
        int           k;
        int           nbusy;
        if (tsub) begin
            es = ta - tb_v;
            ec = (ta >= tb_v);
        end else begin
            tot = {1'b0, ta} + {1'b0, tb_v};
            es  = tot[W-1:0];
            ec  = tot[W];
        end
        a = ta;
        b = tb_v;
`ifdef SERIAL_ADDER_SUB_EN
        sub = tsub;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        check({tag, ".busy_start"}, 32'(busy), 32'd1);
        k = 0;
        nbusy = 0;
        while (done !== 1'b1 && k < W + 4) begin
            if (busy === 1'b1) nbusy++;
            if (k == W / 2) begin
                check({tag, ".hold_sum"}, 32'(sum), 32'(held_sum));
                check({tag, ".hold_cout"}, 32'(cout), 32'(held_cout));
            end
            if (k == glitch_k) begin
                start = 1'b1;
                a = 8'hAA;
                b = 8'h55;
            end
            tick();
            start = 1'b0;
            k++;
        end
        check({tag, ".latency"}, 32'(k), 32'(W));
        check({tag, ".busy_cycles"}, 32'(nbusy), 32'(W));
        check({tag, ".sum"}, 32'(sum), 32'(es));
        check({tag, ".cout"}, 32'(cout), 32'(ec));
        check({tag, ".busy_in_done"}, 32'(busy), 32'd0);
        held_sum  = es;
        held_cout = ec;
    endtask

    initial begin
        int ndone;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        held_sum  = '0;
        held_cout = 1'b0;

        // 1: reset state, then a basic add
        idle(2);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.sum",  32'(sum),  32'd0);
        check("rst.cout", 32'(cout), 32'd0);
        rst = 1'b0;
        tick();
        check("rst.release_busy", 32'(busy), 32'd0);
        do_op("t1", 8'h35, 8'h4A, 1'b0, -1);
        tick();
        check("t1.single_done", 32'(done), 32'd0);

        // 2: wrap-around and max+max
        do_op("t2a", 8'hFF, 8'h01, 1'b0, -1);
        tick();
        check("t2a.single_done", 32'(done), 32'd0);
        do_op("t2b", 8'hFF, 8'hFF, 1'b0, -1);
        idle(2);
        check("t2b.held_sum", 32'(sum), 32'h0FE);
        check("t2b.held_cout", 32'(cout), 32'd1);

        // 3: start during SHIFT is ignored
        do_op("t3", 8'h10, 8'h20, 1'b0, 3);
        tick();
        check("t3.single_done", 32'(done), 32'd0);
        check("t3.back_idle", 32'(busy), 32'd0);

        // 4: reset in mid-operation aborts without done
        a = 8'h0F;
        b = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        idle(4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4.busy", 32'(busy), 32'd0);
        check("t4.done", 32'(done), 32'd0);
        check("t4.sum",  32'(sum),  32'd0);
        check("t4.cout", 32'(cout), 32'd0);
        ndone = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (done === 1'b1) ndone++;
            tick();
        end
        check("t4.no_done", 32'(ndone), 32'd0);
        held_sum  = '0;
        held_cout = 1'b0;
        do_op("t4.fresh", 8'h0F, 8'h01, 1'b0, -1);
        tick();

        // 5: back-to-back request in the DONE cycle
        do_op("t5a", 8'h12, 8'h34, 1'b0, -1);
        do_op("t5b", 8'h80, 8'h80, 1'b0, -1);
        tick();
        check("t5.single_done", 32'(done), 32'd0);

`ifdef SERIAL_ADDER_SUB_EN
        // 6: subtraction
        do_op("t6a", 8'h10, 8'h01, 1'b1, -1);
        tick();
        do_op("t6b", 8'h01, 8'h02, 1'b1, -1);
        tick();
`endif

        // Randomized operations with random gaps (0 = back-to-back)
        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            do_op("rand", ra, rb, rs, -1);
            idle(int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
